vad_decision_ctrl: RTL and testbench

Frame-level decision controller placed after the BNN output layer of the VAD pipeline. It accepts one pair of class scores per audio frame (non-speech, speech) over a valid/ready handshake and compares them. It then applies onset-confirmation and hangover smoothing through a state machine. It emits a registered 2-bit class decision per frame (2'b10 = speech, 2'b01 = non-speech) with backpressure toward the consumer.

---
 rtl/vad_decision_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_vad_decision_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vad_decision_ctrl.sv
// Frame-level VAD decision controller: score compare, onset/hangover FSM,
// registered 2-bit class decision with valid/ready on both sides.
module vad_decision_ctrl #(
  parameter int SCORE_W      = 8,
  parameter int ONSET_FRAMES = 2,
  parameter int HANG_FRAMES  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vad_clr,
  input  logic               score_valid,
  output logic               score_ready,
  input  logic [SCORE_W-1:0] score0,
  input  logic [SCORE_W-1:0] score1,
  input  logic               force_speech,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [1:0]         result,
  output logic [15:0]        frame_cnt
);

  typedef enum logic [1:0] {
    ST_SIL,
    ST_ONSET,
    ST_SPEECH,
    ST_HANG
  } state_t;

  localparam logic [3:0] ONSET_N    = 4'(ONSET_FRAMES);
  localparam logic [3:0] HANG_N     = 4'(HANG_FRAMES);
  localparam logic [1:0] RES_SPEECH = 2'b10;
  localparam logic [1:0] RES_NONSP  = 2'b01;

  state_t      state_q, state_d;
  logic [3:0]  onset_q, onset_d;
  logic [3:0]  hang_q, hang_d;
  logic        s1_valid_q, s1_valid_d;
  logic        cand_q, cand_d;
  logic        result_valid_q, result_valid_d;
  logic [1:0]  result_q, result_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        adv;
  logic        accept;
  logic        load;
  logic        consume;
  logic        new_cand;

  state_t      fsm_state;
  logic [3:0]  fsm_onset;
  logic [3:0]  fsm_hang;
  logic [3:0]  onset_inc;

  always_comb begin
    adv         = !result_valid_q || result_ready;
    score_ready = !s1_valid_q || adv;
    accept      = score_valid && score_ready;
    load        = s1_valid_q && adv;
    consume     = result_valid_q && result_ready;
    new_cand    = force_speech || ($signed(score1) > $signed(score0));
  end

  always_comb begin
    fsm_state = state_q;
    fsm_onset = onset_q;
    fsm_hang  = hang_q;
    onset_inc = onset_q + 4'd1;
    case (state_q)
      ST_SIL: begin
        if (cand_q) begin
          if (ONSET_N == 4'd1) begin
            fsm_state = ST_SPEECH;
            fsm_onset = '0;
          end else begin
            fsm_state = ST_ONSET;
            fsm_onset = 4'd1;
          end
        end
      end
      ST_ONSET: begin
        if (cand_q) begin
          if (onset_inc == ONSET_N) begin
            fsm_state = ST_SPEECH;
            fsm_onset = '0;
          end else begin
            fsm_onset = onset_inc;
          end
        end else begin
          fsm_state = ST_SIL;
          fsm_onset = '0;
        end
      end
      ST_SPEECH: begin
        if (!cand_q) begin
          if (HANG_N == 4'd0) begin
            fsm_state = ST_SIL;
          end else begin
            fsm_state = ST_HANG;
            fsm_hang  = HANG_N;
          end
        end
      end
      ST_HANG: begin
        if (cand_q) begin
          fsm_state = ST_SPEECH;
          fsm_hang  = '0;
        end else if (hang_q == 4'd1) begin
          fsm_state = ST_SIL;
          fsm_hang  = '0;
        end else begin
          fsm_hang  = hang_q - 4'd1;
        end
      end
      default: begin
        fsm_state = ST_SIL;
        fsm_onset = '0;
        fsm_hang  = '0;
      end
    endcase
  end

  // vad_clr wins over every handshake; a frame offered alongside it is dropped.
  always_comb begin
    state_d        = state_q;
    onset_d        = onset_q;
    hang_d         = hang_q;
    cand_d         = cand_q;
    s1_valid_d     = s1_valid_q;
    result_valid_d = result_valid_q;
    result_d       = result_q;
    frame_cnt_d    = frame_cnt_q;

    if (accept) begin
      cand_d = new_cand;
    end
    s1_valid_d = accept || (s1_valid_q && !load);

    if (load) begin
      state_d        = fsm_state;
      onset_d        = fsm_onset;
      hang_d         = fsm_hang;
      result_valid_d = 1'b1;
      result_d       = (fsm_state == ST_SPEECH || fsm_state == ST_HANG) ? RES_SPEECH : RES_NONSP;
    end else if (consume) begin
      result_valid_d = 1'b0;
    end

    if (consume) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    if (vad_clr) begin
      state_d        = ST_SIL;
      onset_d        = '0;
      hang_d         = '0;
      cand_d         = 1'b0;
      s1_valid_d     = 1'b0;
      result_valid_d = 1'b0;
      result_d       = '0;
      frame_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_SIL;
      onset_q        <= '0;
      hang_q         <= '0;
      cand_q         <= 1'b0;
      s1_valid_q     <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      frame_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      onset_q        <= onset_d;
      hang_q         <= hang_d;
      cand_q         <= cand_d;
      s1_valid_q     <= s1_valid_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  always_comb begin
    result_valid = result_valid_q;
    result       = result_q;
    frame_cnt    = frame_cnt_q;
  end

endmodule

// File: tb/tb_vad_decision_ctrl.sv
// Directed bench for vad_decision_ctrl with ONSET_FRAMES=2, HANG_FRAMES=3.
module tb_vad_decision_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vad_clr;
  logic        score_valid;
  logic        score_ready;
  logic [7:0]  score0;
  logic [7:0]  score1;
  logic        force_speech;
  logic        result_valid;
  logic        result_ready;
  logic [1:0]  result;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic signed [7:0] s0;
    logic signed [7:0] s1;
    logic              frc;
    logic [1:0]        exp;
  } vec_t;

  vec_t tbl[$];
  int   grp_lo[7];
  int   grp_n[7];

  vad_decision_ctrl #(
    .SCORE_W(8),
    .ONSET_FRAMES(2),
    .HANG_FRAMES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vad_clr(vad_clr),
    .score_valid(score_valid),
    .score_ready(score_ready),
    .score0(score0),
    .score1(score1),
    .force_speech(force_speech),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result(result),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic signed [7:0] a, input logic signed [7:0] b,
                     input logic f, input logic [1:0] e);
    vec_t v;
    v.s0 = a; v.s1 = b; v.frc = f; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic do_clear();
    vad_clr     = 1'b1;
    score_valid = 1'b0;
    tick();
    vad_clr = 1'b0;
    chk("clr_result", 32'(result), 32'd0);
    chk("clr_valid", 32'(result_valid), 32'd0);
    chk("clr_cnt", 32'(frame_cnt), 32'd0);
  endtask

  // Streams one frame per cycle with result_ready high; decision for frame j
  // must be visible right after the edge following its accept edge.
  task automatic run_group(input int g);
    int lo;
    int n;
    lo = grp_lo[g];
    n  = grp_n[g];
    do_clear();
    result_ready = 1'b1;
    for (int j = 0; j <= n + 1; j++) begin
      if (j < n) begin
        score0       = tbl[lo+j].s0;
        score1       = tbl[lo+j].s1;
        force_speech = tbl[lo+j].frc;
        score_valid  = 1'b1;
      end else begin
        score_valid  = 1'b0;
        force_speech = 1'b0;
      end
      #1;
      if (j < n) chk($sformatf("g%0d_ready%0d", g, j), 32'(score_ready), 32'd1);
      tick();
      chk($sformatf("g%0d_valid%0d", g, j), 32'(result_valid), 32'((j >= 1) && (j <= n)));
      if (j >= 1 && j <= n)
        chk($sformatf("g%0d_dec%0d", g, j - 1), 32'(result), 32'(tbl[lo+j-1].exp));
    end
    chk($sformatf("g%0d_cnt", g), 32'(frame_cnt), 32'(n));
  endtask

  task automatic run_backpressure();
    logic [1:0] bp_exp[5];
    int   sent, got, cyc, bp_left;
    logic first_seen, stall_seen, acc, hold;
    logic [1:0] prev_res;
    bp_exp = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    sent = 0; got = 0; cyc = 0; bp_left = 4;
    first_seen = 1'b0; stall_seen = 1'b0;
    do_clear();
    score0 = 8'sd5;
    score1 = 8'sd9;
    force_speech = 1'b0;
    while (got < 5 && cyc < 40) begin
      score_valid = (sent < 5);
      if (result_valid) first_seen = 1'b1;
      if (first_seen && bp_left > 0) begin
        result_ready = 1'b0;
        bp_left--;
      end else begin
        result_ready = 1'b1;
      end
      #1;
      acc = score_valid && score_ready;
      if (score_valid && !score_ready) stall_seen = 1'b1;
      if (result_valid && result_ready) begin
        chk($sformatf("bp_dec%0d", got), 32'(result), 32'(bp_exp[got]));
        got++;
      end
      hold     = result_valid && !result_ready;
      prev_res = result;
      tick();
      if (acc) sent++;
      if (hold) begin
        chk($sformatf("bp_hold_valid%0d", cyc), 32'(result_valid), 32'd1);
        chk($sformatf("bp_hold_res%0d", cyc), 32'(result), 32'(prev_res));
      end
      cyc++;
    end
    score_valid  = 1'b0;
    result_ready = 1'b1;
    chk("bp_got", 32'(got), 32'd5);
    chk("bp_sent", 32'(sent), 32'd5);
    chk("bp_stall_seen", 32'(stall_seen), 32'd1);
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("bp_no_dup", 32'(result_valid), 32'd0);
  endtask

  initial begin
    // onset defaults
    add(8'sd5, 8'sd9, 1'b0, 2'b01); add(8'sd5, 8'sd9, 1'b0, 2'b10); add(8'sd5, 8'sd9, 1'b0, 2'b10);
    // equal scores return ONSET to SIL
    add(8'sd5, 8'sd9, 1'b0, 2'b01); add(8'sd3, 8'sd3, 1'b0, 2'b01);
    // hangover expiry then onset restart
    add(8'sd5, 8'sd9, 1'b0, 2'b01); add(8'sd5, 8'sd9, 1'b0, 2'b10);
    add(8'sd9, -8'sd2, 1'b0, 2'b10); add(8'sd9, -8'sd2, 1'b0, 2'b10);
    add(8'sd9, -8'sd2, 1'b0, 2'b10); add(8'sd9, -8'sd2, 1'b0, 2'b01);
    add(-8'sd4, 8'sd6, 1'b0, 2'b01);
    // HANG -> SPEECH, then full hangover reload proves SPEECH
    add(8'sd5, 8'sd9, 1'b0, 2'b01); add(8'sd5, 8'sd9, 1'b0, 2'b10);
    add(8'sd9, -8'sd2, 1'b0, 2'b10); add(8'sd1, 8'sd2, 1'b0, 2'b10);
    add(8'sd9, -8'sd2, 1'b0, 2'b10); add(8'sd9, -8'sd2, 1'b0, 2'b10);
    add(8'sd9, -8'sd2, 1'b0, 2'b10); add(8'sd9, -8'sd2, 1'b0, 2'b01);
    // force_speech still goes through onset
    add(8'sd100, -8'sd100, 1'b1, 2'b01); add(8'sd100, -8'sd100, 1'b1, 2'b10);
    // signed compare
    add(-8'sd1, 8'sh80, 1'b0, 2'b01); add(8'sd1, -8'sd1, 1'b0, 2'b01);
    add(-8'sd1, 8'sd1, 1'b0, 2'b01); add(-8'sd1, 8'sd1, 1'b0, 2'b10);
    // reach HANG before the clear test
    add(8'sd5, 8'sd9, 1'b0, 2'b01); add(8'sd5, 8'sd9, 1'b0, 2'b10); add(8'sd9, -8'sd2, 1'b0, 2'b10);

    grp_lo = '{0, 3, 5, 12, 20, 22, 26};
    grp_n  = '{3, 2, 7, 8, 2, 4, 3};

    rst_n = 1'b0; vad_clr = 1'b0; score_valid = 1'b0; force_speech = 1'b0;
    score0 = '0; score1 = '0; result_ready = 1'b1;
    #12;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_ready", 32'(score_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    for (int g = 0; g < 6; g++) run_group(g);

    run_backpressure();

    // clear while in HANG with a frame offered
    run_group(6);
    score0 = 8'sd5; score1 = 8'sd9; score_valid = 1'b1; vad_clr = 1'b1;
    tick();
    vad_clr = 1'b0; score_valid = 1'b0;
    chk("hclr_result", 32'(result), 32'd0);
    chk("hclr_valid", 32'(result_valid), 32'd0);
    chk("hclr_cnt", 32'(frame_cnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hclr_drop%0d", k), 32'(result_valid), 32'd0);
    end
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    tick();
    chk("hclr_sil_valid", 32'(result_valid), 32'd1);
    chk("hclr_sil_dec", 32'(result), 32'd1);

    // async reset mid-stream with a held decision
    tick();
    chk("pre_rst_cnt", 32'(frame_cnt), 32'd1);
    result_ready = 1'b0;
    score_valid  = 1'b1;
    tick();
    score_valid = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(result_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_valid", 32'(result_valid), 32'd0);
    chk("arst_cnt", 32'(frame_cnt), 32'd0);
    chk("arst_ready", 32'(score_ready), 32'd1);
    #2 rst_n = 1'b1;
    result_ready = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
